// File: rtl/router_mc_if.sv
// Flit channel bundle for router_mc: NUM_PORTS input channels plus the CPU and
// forward output channels, each a valid/ready handshake.
interface router_mc_if #(
    parameter int NUM_PORTS  = 4,
    parameter int FLIT_WIDTH = 64
);
    logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit;
    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS-1:0]            in_ready;
    logic [FLIT_WIDTH-1:0]           cpu_flit;
    logic                            cpu_valid;
    logic                            cpu_ready;
    logic [FLIT_WIDTH-1:0]           fwd_flit;
    logic                            fwd_valid;
    logic                            fwd_ready;

    modport master (
        output in_flit, in_valid, cpu_ready, fwd_ready,
        input  in_ready, cpu_flit, cpu_valid, fwd_flit, fwd_valid
    );

    modport slave (
        input  in_flit, in_valid, cpu_ready, fwd_ready,
        output in_ready, cpu_flit, cpu_valid, fwd_flit, fwd_valid
    );
endinterface

// File: rtl/router_mc.sv
// router_mc: wormhole flit router with round-robin head arbitration, one-entry
// CPU/forward output slots, and node ID assignment with a timeout flag.
//
// state  | meaning
// IDLE   | arbitrating among ports offering a head or single flit
// LOCKED | lock_port owns the stored route until its tail is accepted
module router_mc #(
    parameter int NUM_PORTS          = 4,
    parameter int FLIT_WIDTH         = 64,
    parameter int NODE_ID_WIDTH      = 8,
    parameter bit IS_ROOT            = 1'b0,
    parameter int MAX_INTERNAL_TIMER = 100
) (
    input  logic                     nocclk,
    input  logic                     rst,
    router_mc_if.slave               bus,
    input  logic [NODE_ID_WIDTH-1:0] assign_id,
    input  logic                     assign_id_valid,
    output logic [NODE_ID_WIDTH-1:0] this_node_id,
    output logic                     id_valid,
    output logic                     id_timeout
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int TW = $clog2(MAX_INTERNAL_TIMER + 1);
    localparam logic [1:0] KIND_HEAD   = 2'b00;
    localparam logic [1:0] KIND_TAIL   = 2'b10;
    localparam logic [1:0] KIND_SINGLE = 2'b11;

    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nxt;

    logic [PW-1:0]            rr_ptr, lock_port, sel;
    logic                     lock_cpu, lock_fwd;
    logic                     sel_ok, dst_hit, route_cpu, route_fwd;
    logic                     cpu_avail, fwd_avail, route_ok, accept;
    logic [NUM_PORTS-1:0]     cand, in_ready_c;
    logic [FLIT_WIDTH-1:0]    sel_flit, cpu_flit_q, fwd_flit_q;
    logic [1:0]               sel_kind;
    logic [NODE_ID_WIDTH-1:0] sel_dst;
    logic                     cpu_valid_q, fwd_valid_q;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return PW'(s);
    endfunction

    // head (00) and single (11) are the only kinds whose two kind bits match
    always_comb begin
        cand = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            cand[p] = bus.in_valid[p] &&
                      (bus.in_flit[p*FLIT_WIDTH + FLIT_WIDTH - 1] ==
                       bus.in_flit[p*FLIT_WIDTH + FLIT_WIDTH - 2]);
        end
    end

    // reverse scan: the candidate closest to rr_ptr is assigned last and wins
    always_comb begin
        sel    = rr_ptr;
        sel_ok = 1'b0;
        if (state == LOCKED) begin
            sel    = lock_port;
            sel_ok = 1'b1;
        end else begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (cand[wrap_add(rr_ptr, i)]) begin
                    sel    = wrap_add(rr_ptr, i);
                    sel_ok = 1'b1;
                end
            end
        end
    end

    assign sel_flit  = bus.in_flit[int'(sel)*FLIT_WIDTH +: FLIT_WIDTH];
    assign sel_kind  = sel_flit[FLIT_WIDTH-1 -: 2];
    assign sel_dst   = sel_flit[FLIT_WIDTH-3 -: NODE_ID_WIDTH];
    assign dst_hit   = id_valid && (sel_dst == this_node_id);
    assign route_cpu = (state == LOCKED) ? lock_cpu : (dst_hit || (&sel_dst));
    assign route_fwd = (state == LOCKED) ? lock_fwd : !dst_hit;
    assign cpu_avail = !cpu_valid_q || bus.cpu_ready;
    assign fwd_avail = !fwd_valid_q || bus.fwd_ready;
    assign route_ok  = (!route_cpu || cpu_avail) && (!route_fwd || fwd_avail);
    assign accept    = sel_ok && route_ok && !rst && bus.in_valid[sel];

    always_comb begin
        in_ready_c = '0;
        if (sel_ok && route_ok && !rst) in_ready_c[sel] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (state == IDLE && sel_kind == KIND_HEAD)
                state_nxt = LOCKED;
            else if (state == LOCKED && (sel_kind == KIND_TAIL || sel_kind == KIND_SINGLE))
                state_nxt = IDLE;
        end
    end

    always_ff @(posedge nocclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge nocclk) begin
        if (rst) begin
            rr_ptr      <= '0;
            lock_port   <= '0;
            lock_cpu    <= 1'b0;
            lock_fwd    <= 1'b0;
            cpu_valid_q <= 1'b0;
            fwd_valid_q <= 1'b0;
            cpu_flit_q  <= '0;
            fwd_flit_q  <= '0;
        end else begin
            if (accept && state == IDLE) begin
                rr_ptr    <= wrap_add(sel, 1);
                lock_port <= sel;
                lock_cpu  <= route_cpu;
                lock_fwd  <= route_fwd;
            end
            if (accept && route_cpu) begin
                cpu_flit_q  <= sel_flit;
                cpu_valid_q <= 1'b1;
            end else if (bus.cpu_ready) begin
                cpu_valid_q <= 1'b0;
            end
            if (accept && route_fwd) begin
                fwd_flit_q  <= sel_flit;
                fwd_valid_q <= 1'b1;
            end else if (bus.fwd_ready) begin
                fwd_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.cpu_flit  = cpu_flit_q;
    assign bus.cpu_valid = cpu_valid_q;
    assign bus.fwd_flit  = fwd_flit_q;
    assign bus.fwd_valid = fwd_valid_q;

    generate
        if (IS_ROOT) begin : g_root
            logic unused_assign;
            assign unused_assign = ^{assign_id, assign_id_valid};
            assign this_node_id  = '0;
            assign id_valid      = 1'b1;
            assign id_timeout    = 1'b0;
        end else begin : g_leaf
            logic [TW-1:0] timer;
            // timer saturates at the terminal count once the timeout has fired
            always_ff @(posedge nocclk) begin
                if (rst) begin
                    this_node_id <= '1;
                    id_valid     <= 1'b0;
                    id_timeout   <= 1'b0;
                    timer        <= '0;
                end else if (!id_valid) begin
                    if (timer == TW'(MAX_INTERNAL_TIMER - 1)) id_timeout <= 1'b1;
                    else                                      timer      <= timer + TW'(1);
                    if (assign_id_valid) begin
                        this_node_id <= assign_id;
                        id_valid     <= 1'b1;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_router_mc.sv
// Self-checking bench for router_mc: directed scenarios plus a randomized run
// compared cycle by cycle against a queue-based behavioural model.
module tb_router_mc;
    localparam int NP = 4, FW = 64, NW = 8, MAXT = 100;
    localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, SINGLE = 2'b11;

    logic nocclk = 1'b0;
    always #5 nocclk = ~nocclk;

    logic          rst;
    logic [NW-1:0] assign_id;
    logic          assign_id_valid;
    logic [NW-1:0] this_node_id, r_node_id;
    logic          id_valid, id_timeout, r_id_valid, r_id_timeout;

    router_mc_if #(.NUM_PORTS(NP), .FLIT_WIDTH(FW)) bus ();
    router_mc_if #(.NUM_PORTS(NP), .FLIT_WIDTH(FW)) bus_r ();

    router_mc #(.NUM_PORTS(NP), .FLIT_WIDTH(FW), .NODE_ID_WIDTH(NW),
                .IS_ROOT(1'b0), .MAX_INTERNAL_TIMER(MAXT)) dut (
        .nocclk(nocclk), .rst(rst), .bus(bus),
        .assign_id(assign_id), .assign_id_valid(assign_id_valid),
        .this_node_id(this_node_id), .id_valid(id_valid), .id_timeout(id_timeout));

    router_mc #(.NUM_PORTS(NP), .FLIT_WIDTH(FW), .NODE_ID_WIDTH(NW),
                .IS_ROOT(1'b1), .MAX_INTERNAL_TIMER(MAXT)) dut_root (
        .nocclk(nocclk), .rst(rst), .bus(bus_r),
        .assign_id(assign_id), .assign_id_valid(assign_id_valid),
        .this_node_id(r_node_id), .id_valid(r_id_valid), .id_timeout(r_id_timeout));

    int n_pass = 0, n_total = 0;

    logic [FW-1:0] l1 [3];
    logic [FW-1:0] l3 [3];
    logic [FW-1:0] pq [NP][$];

    function automatic logic [FW-1:0] mk_flit(input logic [1:0] kind, input logic [NW-1:0] dst, input int pay);
        logic [FW-1:0] f;
        f = '0;
        f[FW-1 -: 2]  = kind;
        f[FW-3 -: NW] = dst;
        f[31:0]       = pay;
        return f;
    endfunction

    task automatic tick();
        @(posedge nocclk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [FW-1:0] f, input logic v);
        bus.in_flit[p*FW +: FW] = f;
        bus.in_valid[p]         = v;
    endtask

    task automatic idle_inputs();
        bus.in_flit     = '0;
        bus.in_valid    = '0;
        bus.cpu_ready   = 1'b1;
        bus.fwd_ready   = 1'b1;
        assign_id       = '0;
        assign_id_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [FW-1:0] f;
        do_reset();
        bus.cpu_ready = 1'b0;
        bus.fwd_ready = 1'b0;
        set_port(0, mk_flit(SINGLE, 8'h09, 1), 1'b1);
        tick();
        set_port(0, '0, 1'b0);
        f = mk_flit(SINGLE, 8'h09, 2);
        rst = 1'b1;
        bus.fwd_ready = 1'b1;
        set_port(1, f, 1'b1);
        #1;
        n_total++; if (bus.in_ready !== 4'b0000) $display("FAIL reset_cycle_in_ready got=%b exp=0000", bus.in_ready); else n_pass++;
        tick();
        rst = 1'b0;
        n_total++; if (bus.fwd_valid !== 1'b0 || bus.cpu_valid !== 1'b0) $display("FAIL reset_outputs got fwd=%b cpu=%b exp 0 0", bus.fwd_valid, bus.cpu_valid); else n_pass++;
        n_total++; if (this_node_id !== 8'hFF || id_valid !== 1'b0 || id_timeout !== 1'b0) $display("FAIL reset_id got id=%h v=%b to=%b exp ff 0 0", this_node_id, id_valid, id_timeout); else n_pass++;
        n_total++; if (r_node_id !== 8'h00 || r_id_valid !== 1'b1 || r_id_timeout !== 1'b0) $display("FAIL reset_root_id got id=%h v=%b to=%b exp 00 1 0", r_node_id, r_id_valid, r_id_timeout); else n_pass++;
        for (int p = 0; p < NP; p++) set_port(p, mk_flit(SINGLE, 8'h09, p), 1'b1);
        #1;
        n_total++; if (bus.in_ready !== 4'b0001) $display("FAIL reset_rr_start got=%b exp=0001", bus.in_ready); else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= MAXT - 1; k++) tick();
        n_total++; if (id_timeout !== 1'b0) $display("FAIL timeout_early got=%b exp=0", id_timeout); else n_pass++;
        tick();
        n_total++; if (id_timeout !== 1'b1) $display("FAIL timeout_rise got=%b exp=1", id_timeout); else n_pass++;
        repeat (5) tick();
        n_total++; if (id_timeout !== 1'b1 || id_valid !== 1'b0) $display("FAIL timeout_hold got to=%b v=%b exp 1 0", id_timeout, id_valid); else n_pass++;
        assign_id = 8'h05; assign_id_valid = 1'b1;
        tick();
        assign_id_valid = 1'b0;
        n_total++; if (id_valid !== 1'b1 || this_node_id !== 8'h05 || id_timeout !== 1'b1) $display("FAIL id_load got v=%b id=%h to=%b exp 1 05 1", id_valid, this_node_id, id_timeout); else n_pass++;
        assign_id = 8'h07; assign_id_valid = 1'b1;
        tick();
        assign_id_valid = 1'b0;
        n_total++; if (this_node_id !== 8'h05) $display("FAIL id_second_strobe got=%h exp=05", this_node_id); else n_pass++;
    endtask

    task automatic test_cpu_delivery();
        logic [FW-1:0] f;
        f = mk_flit(SINGLE, 8'h05, 32'h35);
        set_port(1, f, 1'b1);
        #1;
        n_total++; if (bus.in_ready !== 4'b0010) $display("FAIL cpu_in_ready got=%b exp=0010", bus.in_ready); else n_pass++;
        tick();
        set_port(1, '0, 1'b0);
        n_total++; if (bus.cpu_valid !== 1'b1 || bus.cpu_flit !== f || bus.fwd_valid !== 1'b0) $display("FAIL cpu_delivery got v=%b flit=%h fwd=%b exp 1 %h 0", bus.cpu_valid, bus.cpu_flit, bus.fwd_valid, f); else n_pass++;
        tick();
        n_total++; if (bus.cpu_valid !== 1'b0) $display("FAIL cpu_drain got=%b exp=0", bus.cpu_valid); else n_pass++;
    endtask

    task automatic test_broadcast_stall();
        logic [FW-1:0] bc;
        bc = mk_flit(SINGLE, 8'hFF, 32'hBC);
        bus.cpu_ready = 1'b0;
        set_port(0, mk_flit(SINGLE, 8'h05, 32'h11), 1'b1);
        #1;
        n_total++; if (bus.in_ready !== 4'b0001) $display("FAIL bcast_fill_ready got=%b exp=0001", bus.in_ready); else n_pass++;
        tick();
        set_port(0, '0, 1'b0);
        set_port(2, bc, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++; if (bus.in_ready !== 4'b0000) $display("FAIL bcast_stall_ready got=%b exp=0000", bus.in_ready); else n_pass++;
            tick();
            n_total++; if (bus.fwd_valid !== 1'b0) $display("FAIL bcast_partial got fwd=%b exp=0", bus.fwd_valid); else n_pass++;
        end
        bus.cpu_ready = 1'b1;
        #1;
        n_total++; if (bus.in_ready !== 4'b0100) $display("FAIL bcast_release_ready got=%b exp=0100", bus.in_ready); else n_pass++;
        tick();
        set_port(2, '0, 1'b0);
        n_total++; if (bus.cpu_valid !== 1'b1 || bus.cpu_flit !== bc || bus.fwd_valid !== 1'b1 || bus.fwd_flit !== bc) $display("FAIL bcast_both got cpu=%b/%h fwd=%b/%h exp 1/%h", bus.cpu_valid, bus.cpu_flit, bus.fwd_valid, bus.fwd_flit, bc); else n_pass++;
        tick();
    endtask

    task automatic test_wormhole();
        logic [FW-1:0] got [$];
        logic [NP-1:0] r;
        int i1, i3;
        do_reset();
        l1[0] = mk_flit(HEAD, 8'h09, 32'h100); l1[1] = mk_flit(BODY, 8'h09, 32'h101); l1[2] = mk_flit(TAIL, 8'h09, 32'h102);
        l3[0] = mk_flit(HEAD, 8'h09, 32'h300); l3[1] = mk_flit(BODY, 8'h09, 32'h301); l3[2] = mk_flit(TAIL, 8'h09, 32'h302);
        i1 = 0; i3 = 0;
        for (int c = 0; c < 20; c++) begin
            set_port(1, (i1 < 3) ? l1[i1] : '0, i1 < 3);
            set_port(3, (i3 < 3) ? l3[i3] : '0, i3 < 3);
            #1;
            r = bus.in_ready;
            tick();
            if (r[1] && i1 < 3) i1++;
            if (r[3] && i3 < 3) i3++;
            if (bus.fwd_valid) got.push_back(bus.fwd_flit);
        end
        idle_inputs();
        n_total++; if (got.size() != 6) $display("FAIL wormhole_count got=%0d exp=6", got.size()); else n_pass++;
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            n_total++;
            if (got[k] !== ((k < 3) ? l1[k] : l3[k-3])) $display("FAIL wormhole_order[%0d] got=%h exp=%h", k, got[k], (k < 3) ? l1[k] : l3[k-3]);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] exp_r;
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, mk_flit(SINGLE, 8'h09, p), 1'b1);
        for (int g = 0; g < 5; g++) begin
            exp_r = '0;
            exp_r[g % NP] = 1'b1;
            #1;
            n_total++; if (bus.in_ready !== exp_r) $display("FAIL rr_grant[%0d] got=%b exp=%b", g, bus.in_ready, exp_r); else n_pass++;
            tick();
            n_total++; if (bus.fwd_valid !== 1'b1 || bus.fwd_flit[31:0] !== 32'(g % NP)) $display("FAIL rr_out[%0d] got v=%b port=%0d exp 1 %0d", g, bus.fwd_valid, bus.fwd_flit[31:0], g % NP); else n_pass++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.fwd_ready = 1'b0;
        set_port(0, mk_flit(HEAD, 8'h09, 32'h50), 1'b1);
        #1;
        n_total++; if (bus.in_ready !== 4'b0001) $display("FAIL midrst_head_ready got=%b exp=0001", bus.in_ready); else n_pass++;
        tick();
        set_port(0, mk_flit(BODY, 8'h09, 32'h51), 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (bus.fwd_valid !== 1'b0 || bus.cpu_valid !== 1'b0) $display("FAIL midrst_outputs got fwd=%b cpu=%b exp 0 0", bus.fwd_valid, bus.cpu_valid); else n_pass++;
        bus.fwd_ready = 1'b1;
        #1;
        n_total++; if (bus.in_ready !== 4'b0000) $display("FAIL midrst_body_ready got=%b exp=0000", bus.in_ready); else n_pass++;
        tick();
        set_port(0, mk_flit(TAIL, 8'h09, 32'h52), 1'b1);
        #1;
        n_total++; if (bus.in_ready !== 4'b0000 || bus.fwd_valid !== 1'b0) $display("FAIL midrst_tail got ready=%b fwd=%b exp 0000 0", bus.in_ready, bus.fwd_valid); else n_pass++;
        idle_inputs();
        tick();
    endtask

    task automatic test_id_same_cycle();
        do_reset();
        assign_id = 8'h05; assign_id_valid = 1'b1;
        set_port(0, mk_flit(SINGLE, 8'h05, 32'h60), 1'b1);
        #1;
        n_total++; if (bus.in_ready !== 4'b0001) $display("FAIL idsame_ready got=%b exp=0001", bus.in_ready); else n_pass++;
        tick();
        assign_id_valid = 1'b0;
        n_total++; if (bus.fwd_valid !== 1'b1 || bus.cpu_valid !== 1'b0 || this_node_id !== 8'h05) $display("FAIL idsame_preload got fwd=%b cpu=%b id=%h exp 1 0 05", bus.fwd_valid, bus.cpu_valid, this_node_id); else n_pass++;
        set_port(0, mk_flit(SINGLE, 8'h05, 32'h61), 1'b1);
        tick();
        set_port(0, '0, 1'b0);
        n_total++; if (bus.cpu_valid !== 1'b1 || bus.fwd_valid !== 1'b0) $display("FAIL idsame_postload got cpu=%b fwd=%b exp 1 0", bus.cpu_valid, bus.fwd_valid); else n_pass++;
        tick();
    endtask

    task automatic gen_packet(input int p);
        int n;
        logic [NW-1:0] d;
        case ($urandom_range(0, 3))
            0:       d = 8'h05;
            1:       d = 8'hFF;
            2:       d = 8'h09;
            default: d = 8'($urandom_range(0, 255));
        endcase
        n = $urandom_range(0, 3);
        if (n == 0) begin
            pq[p].push_back(mk_flit(SINGLE, d, int'($urandom)));
        end else begin
            pq[p].push_back(mk_flit(HEAD, d, int'($urandom)));
            for (int b = 0; b < n - 1; b++) pq[p].push_back(mk_flit(BODY, 8'($urandom_range(0, 255)), int'($urandom)));
            pq[p].push_back(mk_flit(TAIL, 8'($urandom_range(0, 255)), int'($urandom)));
        end
    endtask

    task automatic test_random();
        int            m_owner, m_next, sel;
        bit            m_rc, m_rf, m_cf, m_ff, m_idv, rc, rf, acc, cr, fr, strobe;
        logic [FW-1:0] m_cd, m_fd, cur;
        logic [NW-1:0] m_id, sid, d;
        logic [NP-1:0] iv, er;
        logic [1:0]    k;
        do_reset();
        for (int p = 0; p < NP; p++) pq[p].delete();
        m_owner = -1; m_next = 0; m_rc = 0; m_rf = 0;
        m_cf = 0; m_ff = 0; m_cd = '0; m_fd = '0; m_id = '1; m_idv = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < NP; p++) begin
                if (pq[p].size() == 0) gen_packet(p);
                iv[p] = ($urandom_range(0, 3) != 0);
                set_port(p, pq[p][0], iv[p]);
            end
            cr = ($urandom_range(0, 3) != 0);
            fr = ($urandom_range(0, 3) != 0);
            bus.cpu_ready = cr;
            bus.fwd_ready = fr;
            strobe = (cyc == 3) || ($urandom_range(0, 99) == 0);
            sid = (cyc == 3) ? 8'h05 : 8'($urandom_range(0, 254));
            assign_id = sid;
            assign_id_valid = strobe;

            sel = -1; rc = 0; rf = 0;
            if (m_owner >= 0) begin
                sel = m_owner; rc = m_rc; rf = m_rf;
            end else begin
                for (int j = 0; j < NP; j++) begin
                    int p;
                    p = (m_next + j) % NP;
                    cur = pq[p][0];
                    if (sel < 0 && iv[p] && (cur[FW-1 -: 2] == HEAD || cur[FW-1 -: 2] == SINGLE)) sel = p;
                end
                if (sel >= 0) begin
                    cur = pq[sel][0];
                    d = cur[FW-3 -: NW];
                    if (m_idv && d == m_id) begin rc = 1; rf = 0; end
                    else if (d == 8'hFF)    begin rc = 1; rf = 1; end
                    else                    begin rc = 0; rf = 1; end
                end
            end
            er = '0;
            if (sel >= 0 && (!rc || !m_cf || cr) && (!rf || !m_ff || fr)) er[sel] = 1'b1;
            acc = (sel >= 0) && er[sel] && iv[sel];
            #1;
            n_total++; if (bus.in_ready !== er) $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, er); else n_pass++;
            tick();

            if (acc) cur = pq[sel][0];
            if (acc && rc) begin m_cf = 1; m_cd = cur; end else if (cr) m_cf = 0;
            if (acc && rf) begin m_ff = 1; m_fd = cur; end else if (fr) m_ff = 0;
            if (acc) begin
                k = cur[FW-1 -: 2];
                if (m_owner < 0) begin
                    m_next = (sel + 1) % NP;
                    if (k == HEAD) begin m_owner = sel; m_rc = rc; m_rf = rf; end
                end else if (k == TAIL || k == SINGLE) begin
                    m_owner = -1;
                end
                void'(pq[sel].pop_front());
            end
            if (strobe && !m_idv) begin m_id = sid; m_idv = 1; end

            n_total++; if (bus.cpu_valid !== m_cf || (m_cf && bus.cpu_flit !== m_cd)) $display("FAIL rand_cpu cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.cpu_valid, bus.cpu_flit, m_cf, m_cd); else n_pass++;
            n_total++; if (bus.fwd_valid !== m_ff || (m_ff && bus.fwd_flit !== m_fd)) $display("FAIL rand_fwd cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.fwd_valid, bus.fwd_flit, m_ff, m_fd); else n_pass++;
            n_total++; if (id_valid !== m_idv || this_node_id !== m_id) $display("FAIL rand_id cyc=%0d got=%b/%h exp=%b/%h", cyc, id_valid, this_node_id, m_idv, m_id); else n_pass++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_root();
        assign_id = 8'h33; assign_id_valid = 1'b1;
        tick();
        assign_id_valid = 1'b0;
        n_total++; if (r_node_id !== 8'h00 || r_id_valid !== 1'b1 || r_id_timeout !== 1'b0) $display("FAIL root_id got id=%h v=%b to=%b exp 00 1 0", r_node_id, r_id_valid, r_id_timeout); else n_pass++;
        n_total++; if (bus_r.in_ready !== 4'b0000 || bus_r.cpu_valid !== 1'b0 || bus_r.fwd_valid !== 1'b0) $display("FAIL root_idle got ready=%b cpu=%b fwd=%b exp 0000 0 0", bus_r.in_ready, bus_r.cpu_valid, bus_r.fwd_valid); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        bus_r.in_flit   = '0;
        bus_r.in_valid  = '0;
        bus_r.cpu_ready = 1'b1;
        bus_r.fwd_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_timeout();
        test_cpu_delivery();
        test_broadcast_stall();
        test_wormhole();
        test_round_robin();
        test_reset_mid_packet();
        test_id_same_cycle();
        test_random();
        test_root();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/router_mc.md
ROUTER_MC -- requirements
Module: router_mc

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of input channels; port 0 is the local CPU; the range is 2..8.
REQ-002 Parameter FLIT_WIDTH, default 64: flit width in bits.
REQ-003 Parameter NODE_ID_WIDTH, default 8: node ID width.
REQ-004 Parameter IS_ROOT, default 0: when 1, the node ID is fixed at 0.
REQ-005 Parameter MAX_INTERNAL_TIMER, default 100: cycles allowed for ID assignment before timeout.
REQ-006 Port nocclk, in, 1: the single clock.
REQ-007 Port rst, in, 1: synchronous, active-high reset.
REQ-008 Port in_flit, in, NUM_PORTS*FLIT_WIDTH: input flits; port p occupies slice p.
REQ-009 Port in_valid, in, NUM_PORTS: per-port valid.
REQ-010 Port in_ready, out, NUM_PORTS: per-port ready.
REQ-011 Port assign_id, in, NODE_ID_WIDTH: ID value to load.
REQ-012 Port assign_id_valid, in, 1: one-cycle load strobe.
REQ-013 Ports cpu_flit (out, FLIT_WIDTH), cpu_valid (out, 1) and cpu_ready (in, 1): the delivery channel to the CPU.
REQ-014 Ports fwd_flit (out, FLIT_WIDTH), fwd_valid (out, 1) and fwd_ready (in, 1): the forwarding channel to the network.
REQ-015 Port this_node_id, out, NODE_ID_WIDTH: the current node ID.
REQ-016 Port id_valid, out, 1: the node ID has been assigned.
REQ-017 Port id_timeout, out, 1: sticky flag; ID assignment timer expired.

Function
REQ-018 The flit kind field SHALL be bits [FLIT_WIDTH-1:FLIT_WIDTH-2]: 00 head, 01 body, 10 tail, 11 single.
REQ-019 The destination ID SHALL be bits [FLIT_WIDTH-3:FLIT_WIDTH-2-NODE_ID_WIDTH] of a head or single flit.
REQ-020 A flit SHALL transfer on any channel only in a cycle where both valid and ready are high.
REQ-021 Routing SHALL be decided from the head or single flit only:
- dst == this_node_id with id_valid=1 -> CPU.
- dst all-ones -> broadcast to CPU and forward.
- anything else -> forward.
REQ-022 Wormhole: after a head is accepted, the router SHALL lock the winning port and route until that port's tail is accepted; body and tail flits SHALL follow the head's route.
REQ-023 When unlocked, a round-robin arbiter SHALL pick among ports with in_valid=1 and kind head or single, starting from the port after the last winner. After reset the search starts at port 0.
REQ-024 In the unlocked state, body or tail flits SHALL NOT be accepted (in_ready=0) and are a protocol error.
REQ-025 Each output SHALL be a one-entry register slot. A slot is available when it is empty, or when it is full and its ready is high in the same cycle.
REQ-026 in_ready[p] SHALL be 1 only for the selected port, and only when every destination slot of the current route is available. Broadcast requires both slots available; no partial transfer is allowed.
REQ-027 Latency SHALL be 1 cycle: a flit accepted at edge N is valid on its output(s) after edge N; one flit per cycle sustained when ready is held high.
REQ-028 A single flit SHALL release the lock in the same cycle it is accepted. The arbiter SHALL re-arbitrate the next cycle with no bubble.
REQ-029 State machine:
- IDLE -> LOCKED on head acceptance.
- LOCKED -> IDLE on tail acceptance.
- IDLE stays IDLE on single-flit acceptance.
REQ-030 Node ID, IS_ROOT=1: this_node_id=0 and id_valid=1 from reset; assign_id_valid is ignored; id_timeout stays 0.
REQ-031 Node ID, IS_ROOT=0, while id_valid=0:
- A counter increments each cycle.
- id_timeout sets when the count reaches MAX_INTERNAL_TIMER-1 and holds until reset.
- assign_id_valid loads assign_id and sets id_valid=1, which also stops the counter.
- Later strobes are ignored.
REQ-032 An ID load and a head routing decision in the same cycle: the decision SHALL use the pre-load ID.

Reset
REQ-033 On rst=1 at a clock edge, the block SHALL set:
- cpu_valid=0 and fwd_valid=0.
- in_ready=0 during the reset cycle.
- State IDLE; round-robin pointer to port 0.
- Timer 0; id_timeout=0.
- IS_ROOT=0: this_node_id all-ones and id_valid=0. IS_ROOT=1: this_node_id=0 and id_valid=1.
REQ-034 Reset mid-packet SHALL drop the lock and any held flits; the next accepted flit must be a head or single.

Verification
REQ-035 Scenario: IS_ROOT=0, assign_id=5 strobe, then a single flit with dst=5 on port 1 -> cpu_valid=1 with that flit one cycle later; fwd_valid=0.
REQ-036 Scenario: single flit with dst=0xFF on port 2, cpu_ready=0, fwd_ready=1 -> in_ready[2]=0 until cpu_ready=1; the flit then appears on both outputs in the same cycle.
REQ-037 Scenario: ports 1 and 3 each send head, body, tail with dst=9 while port 3 is valid throughout -> port 1's three flits appear contiguously on fwd before any flit from port 3.
REQ-038 Scenario: all ports hold single flits valid continuously, both readies at 1 -> grants go 0,1,2,3,0; one flit out per cycle.
REQ-039 Scenario: MAX_INTERNAL_TIMER=100, no assign -> id_timeout rises after the 100th cycle post-reset and stays high; a later assign sets id_valid while id_timeout remains 1.
REQ-040 Scenario: rst asserted after a head, before its tail -> outputs invalid next cycle; a following body flit on that port sees in_ready=0.
